// File: rtl/output_frame_serializer.sv
// ---------------------------------------------------------------------------
// output_frame_serializer
//
// Transmit side of the stereo serial frame interface. A parallel L/R result
// pair is accepted over a valid/ready handshake into a one-deep holding
// buffer. Each frame_pulse moves the held pair into the shifters. The pair
// is then sent MSB-first on OutputL/OutputR, one bit per clock. OutReady
// marks the cycles that carry valid bits.
//
// Ports
//   clk          system clock; all state updates on posedge
//   restart      synchronous active-high reset
//   frame_pulse  1-cycle pulse marking the start of an output frame
//   in_valid     dataL/dataR valid
//   in_ready     holding buffer empty; a word can be accepted
//   dataL/dataR  left/right result words (DATA_W bits)
//   OutputL/R    serial bit streams, MSB first
//   OutReady     high while valid bits are on OutputL/R
//   busy         frame transmission in progress
//   underrun     sticky: frame_pulse seen with the holding buffer empty
//   overrun      sticky: frame_pulse seen while a frame was being shifted
// ---------------------------------------------------------------------------
module output_frame_serializer #(
    parameter int DATA_W = 40
) (
    input  logic              clk,
    input  logic              restart,
    input  logic              frame_pulse,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] dataL,
    input  logic [DATA_W-1:0] dataR,
    output logic              OutputL,
    output logic              OutputR,
    output logic              OutReady,
    output logic              busy,
    output logic              underrun,
    output logic              overrun
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_reg;
    logic [DATA_W-1:0]  hold_l_reg;
    logic [DATA_W-1:0]  hold_r_reg;
    logic               hold_full_reg;
    logic [DATA_W-1:0]  shift_l_reg;
    logic [DATA_W-1:0]  shift_r_reg;
    logic [CNT_W-1:0]   bitcnt_reg;
    logic               out_l_reg;
    logic               out_r_reg;
    logic               out_ready_reg;
    logic               busy_reg;
    logic               underrun_reg;
    logic               overrun_reg;
    logic               accept;

    assign in_ready = !hold_full_reg;
    assign accept   = in_valid && !hold_full_reg;

    always_ff @(posedge clk) begin
        if (restart) begin
            state_reg     <= IDLE;
            hold_l_reg    <= '0;
            hold_r_reg    <= '0;
            hold_full_reg <= 1'b0;
            shift_l_reg   <= '0;
            shift_r_reg   <= '0;
            bitcnt_reg    <= '0;
            out_l_reg     <= 1'b0;
            out_r_reg     <= 1'b0;
            out_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
            underrun_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            // An accept needs the buffer empty, and a transfer to the
            // shifter needs it full, so the two never collide on hold_full.
            if (accept) begin
                hold_l_reg    <= dataL;
                hold_r_reg    <= dataR;
                hold_full_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    out_l_reg     <= 1'b0;
                    out_r_reg     <= 1'b0;
                    out_ready_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    if (frame_pulse) begin
                        // The buffer is checked as it stands before this edge.
                        // A word accepted on the same edge waits for the next pulse.
                        if (hold_full_reg) begin
                            shift_l_reg   <= hold_l_reg;
                            shift_r_reg   <= hold_r_reg;
                            hold_full_reg <= 1'b0;
                            bitcnt_reg    <= LAST_BIT;
                            state_reg     <= SHIFT;
                        end else begin
                            underrun_reg <= 1'b1;
                        end
                    end
                end

                SHIFT: begin
                    out_l_reg     <= shift_l_reg[DATA_W-1];
                    out_r_reg     <= shift_r_reg[DATA_W-1];
                    out_ready_reg <= 1'b1;
                    busy_reg      <= 1'b1;
                    shift_l_reg   <= shift_l_reg << 1;
                    shift_r_reg   <= shift_r_reg << 1;
                    bitcnt_reg    <= bitcnt_reg - 1'b1;
                    if (bitcnt_reg == '0) begin
                        state_reg <= IDLE;
                    end
                    // A frame in flight is never disturbed; the pulse is only flagged.
                    if (frame_pulse) begin
                        overrun_reg <= 1'b1;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign OutputL  = out_l_reg;
    assign OutputR  = out_r_reg;
    assign OutReady = out_ready_reg;
    assign busy     = busy_reg;
    assign underrun = underrun_reg;
    assign overrun  = overrun_reg;

endmodule

// File: tb/tb_output_frame_serializer.sv
module tb_output_frame_serializer;

    logic        clk;
    logic        restart;
    logic        frame_pulse;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] data_l;
    logic [39:0] data_r;
    logic        out_l;
    logic        out_r;
    logic        out_ready;
    logic        busy;
    logic        underrun;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    output_frame_serializer #(.DATA_W(40)) dut (
        .clk         (clk),
        .restart     (restart),
        .frame_pulse (frame_pulse),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dataL       (data_l),
        .dataR       (data_r),
        .OutputL     (out_l),
        .OutputR     (out_r),
        .OutReady    (out_ready),
        .busy        (busy),
        .underrun    (underrun),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the active edge; inputs are
    // driven at the same point so they are stable for the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One serial bit of a frame: i = 0 is the MSB.
    task automatic chk_bit(input string tag, input logic [39:0] l, input logic [39:0] r, input int i);
        logic [5:0] idx;
        idx = 6'(39 - i);
        chk({tag, "_outready"}, out_ready, 1'b1);
        chk({tag, "_busy"},     busy,      1'b1);
        chk({tag, "_l"},        out_l,     l[idx]);
        chk({tag, "_r"},        out_r,     r[idx]);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_outready"}, out_ready, 1'b0);
        chk({tag, "_busy"},     busy,      1'b0);
        chk({tag, "_l"},        out_l,     1'b0);
        chk({tag, "_r"},        out_r,     1'b0);
    endtask

    task automatic load(input string tag, input logic [39:0] l, input logic [39:0] r);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_ready_before"}, in_ready, 1'b1);
        in_valid = 1'b1;
        data_l   = l;
        data_r   = r;
        tick();
        in_valid = 1'b0;
        chk({tag, "_ready_after"}, in_ready, 1'b0);
        $display("load %s L=%h R=%h", tag, l, r);
    endtask

    task automatic pulse();
        frame_pulse = 1'b1;
        tick();
        frame_pulse = 1'b0;
    endtask

    logic [39:0] wl, wr, bl, br;

    initial begin
        restart     = 1'b1;
        frame_pulse = 1'b0;
        in_valid    = 1'b0;
        data_l      = '0;
        data_r      = '0;

        // 1. Reset state
        tick();
        tick();
        restart = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk_idle("rst");
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_overrun",  overrun,  1'b0);
        $display("reset done");

        // 2. Single frame with hand-chosen bit patterns
        wl = 40'h80_0000_0001;
        wr = 40'h00_0000_0003;
        load("t2", wl, wr);
        pulse();                               // edge T
        chk("t2_in_ready_T", in_ready, 1'b1);
        for (int i = 0; i < 40; i++) begin
            tick();                            // edge T+1+i
            chk_bit("t2", wl, wr, i);
        end
        tick();                                // edge T+41
        chk_idle("t2_end");
        chk("t2_underrun", underrun, 1'b0);
        $display("frame t2 sent");

        // 3. Back-to-back frames, second word loaded during the first frame
        wl = 40'hA5_5AC3_3C0F;
        wr = 40'h0F_F00F_F0A5;
        bl = 40'h12_3456_789A;
        br = 40'hFE_DCBA_9876;
        load("t3a", wl, wr);
        pulse();                               // edge T
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin
                in_valid = 1'b1;
                data_l   = bl;
                data_r   = br;
            end
            if (i == 6) begin
                // A different word offered while full must be ignored.
                in_valid = 1'b1;
                data_l   = 40'hFF_FFFF_FFFF;
                data_r   = 40'hFF_FFFF_FFFF;
            end
            if (i == 7) in_valid = 1'b0;
            tick();                            // edge T+i
            chk_bit("t3a", wl, wr, i - 1);
            chk("t3_in_ready", in_ready, (i >= 5) ? 1'b0 : 1'b1);
        end
        in_valid = 1'b0;
        pulse();                               // edge T+41: gap cycle, B loads
        chk_idle("t3_gap");
        chk("t3_in_ready_T41", in_ready, 1'b1);
        for (int i = 0; i < 40; i++) begin
            tick();                            // edges T+42..T+81
            chk_bit("t3b", bl, br, i);
        end
        tick();
        chk_idle("t3_end");
        chk("t3_overrun", overrun, 1'b0);
        $display("frames t3 A/B sent back-to-back");

        // 4. Underrun with empty buffer, plus pulse coinciding with an accept
        pulse();
        chk_idle("t4_pulse");
        chk("t4_underrun", underrun, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk_idle("t4_later");
        chk("t4_underrun_sticky", underrun, 1'b1);
        wl = 40'hC0_0000_0000;
        wr = 40'h00_0000_0001;
        frame_pulse = 1'b1;
        in_valid    = 1'b1;
        data_l      = wl;
        data_r      = wr;
        tick();
        frame_pulse = 1'b0;
        in_valid    = 1'b0;
        chk("t4_sim_loaded", in_ready, 1'b0);
        tick();
        chk_idle("t4_sim_nosend");
        pulse();
        for (int i = 0; i < 40; i++) begin
            tick();
            chk_bit("t4", wl, wr, i);
        end
        tick();
        chk_idle("t4_end");
        chk("t4_underrun_still", underrun, 1'b1);
        $display("underrun case done");

        // 5. Overrun: pulse in the middle of a frame
        wl = 40'h69_96A5_5AF0;
        wr = 40'h3C_C3E1_1E87;
        load("t5", wl, wr);
        pulse();                               // edge T
        for (int i = 1; i <= 40; i++) begin
            frame_pulse = (i == 20);
            tick();
            chk_bit("t5", wl, wr, i - 1);
            chk("t5_overrun", overrun, (i >= 20) ? 1'b1 : 1'b0);
        end
        frame_pulse = 1'b0;
        tick();
        chk_idle("t5_end");
        tick();
        chk_idle("t5_nonew");
        chk("t5_overrun_sticky", overrun, 1'b1);
        $display("overrun case done");

        // 6. Restart in mid-frame
        wl = 40'hFF_FFFF_FFFF;
        wr = 40'hFF_FFFF_FFFF;
        load("t6", wl, wr);
        pulse();
        for (int i = 0; i < 16; i++) begin
            tick();
            chk_bit("t6", wl, wr, i);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk_idle("t6_rst");
        chk("t6_in_ready", in_ready, 1'b1);
        chk("t6_underrun_clr", underrun, 1'b0);
        chk("t6_overrun_clr",  overrun,  1'b0);
        pulse();
        chk_idle("t6_pulse");
        chk("t6_underrun", underrun, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        chk_idle("t6_after");
        $display("restart case done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
